// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: FIFO of ALU commands issued on a registered ALU port when Run is high.
// Define ALU_CMD_COUNT_EN to build the Issued_count counter; otherwise Issued_count is tied to 0.
module alu_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     In_valid,
  input  logic [1:0]               In_function,
  input  logic [3:0]               In_data,
  output logic                     In_ready,
  input  logic                     Run,
  input  logic                     Flush,
  output logic [1:0]               Function,
  output logic [3:0]               Data,
  output logic                     Issue,
  output logic [$clog2(DEPTH):0]   Level,
  output logic [7:0]               Issued_count
);
  localparam int AW = $clog2(DEPTH);
  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  assign In_ready = (Level != (AW+1)'(DEPTH)) && !Flush;
  assign push     = In_valid && In_ready;
  assign pop      = Run && (Level != '0) && !Flush;
  always_ff @(posedge Clock)
    if (push && !Reset) mem[wr_ptr] <= {In_function, In_data};
  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      Level    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Function <= 2'b11;
      Data     <= 4'h0;
      Issue    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      Level    <= Level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      Function <= pop ? mem[rd_ptr][5:4] : 2'b11;
      Data     <= pop ? mem[rd_ptr][3:0] : 4'h0;
      Issue    <= pop;
    end
  end
`ifdef ALU_CMD_COUNT_EN
  always_ff @(posedge Clock)
    if (Reset) Issued_count <= 8'h00;
    else if (pop) Issued_count <= Issued_count + 8'h01;
`else
  assign Issued_count = 8'h00;
`endif
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: directed self-checking bench for alu_cmd_queue at DEPTH=4.
module tb_alu_cmd_queue;
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       In_valid = 1'b0;
  logic [1:0] In_function = 2'b00;
  logic [3:0] In_data = 4'h0;
  logic       In_ready;
  logic       Run = 1'b0;
  logic       Flush = 1'b0;
  logic [1:0] Function;
  logic [3:0] Data;
  logic       Issue;
  logic [2:0] Level;
  logic [7:0] Issued_count;
  int passed = 0;
  int total = 0;
`ifdef ALU_CMD_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  alu_cmd_queue #(.DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .In_valid(In_valid), .In_function(In_function),
    .In_data(In_data), .In_ready(In_ready), .Run(Run), .Flush(Flush),
    .Function(Function), .Data(Data), .Issue(Issue), .Level(Level),
    .Issued_count(Issued_count)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] cnt(input int n);
    return CNT_EN ? 8'(n) : 8'h00;
  endfunction

  task automatic hold_out(input string tag);
    chk({tag, "_issue"}, {7'd0, Issue}, 8'd0);
    chk({tag, "_func"}, {6'd0, Function}, 8'h03);
    chk({tag, "_data"}, {4'd0, Data}, 8'h00);
  endtask

  task automatic issued(input string tag, input logic [1:0] f, input logic [3:0] d);
    chk({tag, "_issue"}, {7'd0, Issue}, 8'd1);
    chk({tag, "_func"}, {6'd0, Function}, {6'd0, f});
    chk({tag, "_data"}, {4'd0, Data}, {4'd0, d});
  endtask

  initial begin
    int n;
    logic acc;
    Reset = 1'b1;
    tick;
    hold_out("rst");
    chk("rst_level", {5'd0, Level}, 8'd0);
    chk("rst_cnt", Issued_count, 8'h00);
    chk("rst_ready", {7'd0, In_ready}, 8'd1);
    Reset = 1'b0;

    In_valid = 1'b1; In_function = 2'b01; In_data = 4'h3;
    tick;
    In_function = 2'b00; In_data = 4'h5;
    tick;
    In_valid = 1'b0;
    chk("two_level", {5'd0, Level}, 8'd2);
    hold_out("two_idle");
    Run = 1'b1;
    tick;
    issued("pop1", 2'b01, 4'h3);
    chk("pop1_level", {5'd0, Level}, 8'd1);
    tick;
    issued("pop2", 2'b00, 4'h5);
    chk("pop2_level", {5'd0, Level}, 8'd0);
    tick;
    hold_out("empty_run");
    In_valid = 1'b1; In_function = 2'b10; In_data = 4'hA;
    tick;
    In_valid = 1'b0;
    chk("lat_n_issue", {7'd0, Issue}, 8'd0);
    chk("lat_n_level", {5'd0, Level}, 8'd1);
    tick;
    issued("lat_n1", 2'b10, 4'hA);
    Run = 1'b0;
    chk("cnt3", Issued_count, cnt(3));

    for (int i = 0; i < 5; i++) begin
      In_valid = 1'b1; In_function = 2'(i); In_data = 4'(i + 1);
      tick;
      chk($sformatf("fill_ready%0d", i), {7'd0, In_ready}, {7'd0, i < 3});
      chk($sformatf("fill_level%0d", i), {5'd0, Level}, 8'(i < 4 ? i + 1 : 4));
    end
    In_valid = 1'b0;
    Run = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick;
      issued($sformatf("drain%0d", j), 2'(j), 4'(j + 1));
    end
    tick;
    hold_out("drain_end");
    chk("drain_level", {5'd0, Level}, 8'd0);
    Run = 1'b0;
    chk("cnt7", Issued_count, cnt(7));

    for (int k = 0; k < 4; k++) begin
      In_valid = 1'b1; In_function = 2'(k); In_data = 4'(k);
      tick;
    end
    chk("wrap_full", {5'd0, Level}, 8'd4);
    Run = 1'b1;
    n = 4;
    for (int j = 0; j < 12; j++) begin
      In_function = 2'(n); In_data = 4'(n);
      acc = In_ready;
      tick;
      issued($sformatf("wrap%0d", j), 2'(j), 4'(j));
      chk($sformatf("wrap_level%0d", j), {5'd0, Level}, 8'd3);
      if (acc) n++;
    end
    chk("wrap_pushes", 8'(n), 8'd15);
    In_valid = 1'b0; Run = 1'b0;
    tick;
    chk("pre_flush_level", {5'd0, Level}, 8'd3);
    chk("cnt19", Issued_count, cnt(19));

    Flush = 1'b1; In_valid = 1'b1; Run = 1'b1; In_function = 2'b01; In_data = 4'h7;
    #1;
    chk("flush_ready", {7'd0, In_ready}, 8'd0);
    tick;
    chk("flush_level", {5'd0, Level}, 8'd0);
    hold_out("flush");
    chk("flush_cnt", Issued_count, cnt(19));
    Flush = 1'b0; In_valid = 1'b0; Run = 1'b0;
    tick;
    chk("post_flush_level", {5'd0, Level}, 8'd0);
    chk("post_flush_ready", {7'd0, In_ready}, 8'd1);

    In_valid = 1'b1; In_function = 2'b10; In_data = 4'h9;
    tick;
    tick;
    In_valid = 1'b0;
    chk("prerst_level", {5'd0, Level}, 8'd2);
    Run = 1'b1; Reset = 1'b1;
    tick;
    Reset = 1'b0; Run = 1'b0;
    chk("midrst_level", {5'd0, Level}, 8'd0);
    hold_out("midrst");
    chk("midrst_cnt", Issued_count, 8'h00);

    In_valid = 1'b1; Run = 1'b1; In_function = 2'b01; In_data = 4'h6;
    for (int t = 0; t < 257; t++) tick;
    chk("cnt256", Issued_count, 8'h00);
    tick;
    In_valid = 1'b0; Run = 1'b0;
    chk("cnt257", Issued_count, cnt(257));
    chk("cnt_level", {5'd0, Level}, 8'd1);
    tick;
    chk("cnt_hold", Issued_count, cnt(257));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of command entries (power of 2, min 2).
REQ-002 The block SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port Reset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 The block SHALL have port In_valid  input  1  producer offers a command this cycle.
REQ-005 The block SHALL have port In_function  input  2  offered ALU function code.
REQ-006 The block SHALL have port In_data  input  4  offered ALU operand.
REQ-007 The block SHALL have port In_ready  output  1  queue can accept a command this cycle.
REQ-008 The block SHALL have port Run  input  1  enables issuing commands to the ALU.
REQ-009 The block SHALL have port Flush  input  1  discards all queued commands.
REQ-010 The block SHALL have port Function  output  2  registered function code to the downstream ALU.
REQ-011 The block SHALL have port Data  output  4  registered operand to the downstream ALU.
REQ-012 The block SHALL have port Issue  output  1  registered; high when Function/Data carry a real popped command.
REQ-013 The block SHALL have port Level  output  log2(DEPTH)+1  number of queued entries.
REQ-014 The block SHALL have port Issued_count  output  8  count of issued commands.

Function
REQ-015 The queue SHALL store {In_function, In_data} entries in FIFO order; a push occurs on a rising edge when In_valid=1 and In_ready=1.
REQ-016 In_ready SHALL equal (Level != DEPTH) && !Flush, derived from registered state only.
REQ-017 A pop SHALL occur on a rising edge when Run=1, Level!=0 and Flush=0; Function/Data SHALL load the head entry and Issue SHALL be 1 for that cycle.
REQ-018 On any edge without a pop, Function SHALL load 2'b11 (ALU hold), Data SHALL load 4'h0, Issue SHALL load 0.
REQ-019 Minimum latency: command pushed at edge N SHALL appear on Function/Data at edge N+1 at the earliest, never at edge N.
REQ-020 Push and pop in the same edge SHALL both take effect; Level unchanged.
REQ-021 When full, In_valid SHALL be ignored (no push, no overwrite), even if a pop occurs that edge.
REQ-022 When empty, Run=1 SHALL produce no pop; pointers SHALL not move.
REQ-023 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 Flush=1 SHALL, at that edge, set Level=0, reset both pointers, suppress push and pop, and drive the hold outputs of REQ-018.
REQ-025 Issued_count SHALL increment by 1 on each pop, wrapping 8'hFF -> 8'h00; Flush SHALL not clear it.

Reset
REQ-026 On an edge with Reset=1, Level SHALL become 0, pointers 0, Function=2'b11, Data=4'h0, Issue=0, Issued_count=8'h00.
REQ-027 Reset SHALL take priority over Flush, push and pop; queued entries SHALL be discarded when asserted mid-operation.
REQ-028 Storage array contents SHALL not require reset.

Configuration
REQ-029 With macro ALU_CMD_COUNT_EN defined, Issued_count SHALL behave per REQ-025.
REQ-030 Without ALU_CMD_COUNT_EN, Issued_count SHALL be constant 8'h00 and no counter register SHALL be synthesized; all other behaviour unchanged.

Verification
REQ-031 Reset, then push {01,4'h3},{00,4'h5} with Run=0 -> Level=2, Issue=0, Function=2'b11; raise Run -> two consecutive Issue cycles carrying 01/3 then 00/5, then Function=2'b11.
REQ-032 DEPTH=4, Run=0, offer 5 commands -> In_ready=0 after 4th, 5th ignored, Level=4; drain -> first four in order.
REQ-033 Full queue, Run=1, In_valid=1 held -> pop each edge, push only on edges where Level<4 at start; order preserved across pointer wrap (>=10 commands).
REQ-034 Level=3, assert Flush with In_valid=1 and Run=1 -> Level=0, Issue=0, Function=2'b11 next cycle; Issued_count unchanged.
REQ-035 With ALU_CMD_COUNT_EN, issue 257 commands -> Issued_count=8'h01; without macro -> 8'h00 throughout.
REQ-036 Reset asserted with Level=2 and Run=1 -> next edge Level=0, Issue=0, Function=2'b11, Data=4'h0, Issued_count=8'h00.
